// File: rtl/bus_demux.sv
// Single-master to three-slave request demultiplexer (DM, TC0, TC1) with
// one outstanding transaction and a bounded wait for read responses.
module bus_demux #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               m_valid,
  output logic               m_ready,
  input  logic [31:0]        m_addr,
  input  logic               m_we,
  input  logic [WIDTH-1:0]   m_wdata,
  output logic               m_rvalid,
  output logic [WIDTH-1:0]   m_rdata,
  output logic               m_err,
  output logic [2:0]         s_valid,
  input  logic [2:0]         s_ready,
  output logic [31:0]        s_addr,
  output logic               s_we,
  output logic [WIDTH-1:0]   s_wdata,
  input  logic [2:0]         s_rvalid,
  input  logic [3*WIDTH-1:0] s_rdata
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t           state_q, state_d;
  logic [2:0]       tgt_q, tgt_d, tgt_dec;
  logic [2:0]       s_valid_q, s_valid_d;
  logic [31:0]      addr_q, addr_d;
  logic             we_q, we_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic [WIDTH-1:0] slice_sel;
  logic             err_q, err_d;
  logic             rvalid_q, rvalid_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // One-hot target decode; all-zero means unmapped.
  always_comb begin
    tgt_dec = 3'b000;
    if (m_addr <= 32'h0000_2FFF)
      tgt_dec = 3'b001;
    else if (m_addr >= 32'h0000_7F00 && m_addr <= 32'h0000_7F0B)
      tgt_dec = 3'b010;
    else if (m_addr >= 32'h0000_7F10 && m_addr <= 32'h0000_7F1B)
      tgt_dec = 3'b100;
  end

  always_comb begin
    slice_sel = '0;
    for (int k = 0; k < 3; k++)
      if (tgt_q[k]) slice_sel = s_rdata[k*WIDTH +: WIDTH];
  end

  always_comb begin
    state_d   = state_q;
    tgt_d     = tgt_q;
    addr_d    = addr_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    s_valid_d = 3'b000;
    rvalid_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (m_valid) begin
          addr_d  = m_addr;
          we_d    = m_we;
          wdata_d = m_wdata;
          tgt_d   = tgt_dec;
          if (tgt_dec != 3'b000) begin
            state_d   = REQ;
            s_valid_d = tgt_dec;
          end else begin
            state_d  = DONE;
            err_d    = 1'b1;
            rdata_d  = '0;
            rvalid_d = 1'b1;
          end
        end
      end
      REQ: begin
        if ((s_ready & tgt_q) != 3'b000) begin
          if (we_q) begin
            state_d  = DONE;
            err_d    = 1'b0;
            rdata_d  = '0;
            rvalid_d = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = '0;
          end
        end else begin
          s_valid_d = s_valid_q;
        end
      end
      WAIT: begin
        // A response in the final counted cycle still wins over the timeout.
        if ((s_rvalid & tgt_q) != 3'b000) begin
          state_d  = DONE;
          err_d    = 1'b0;
          rdata_d  = slice_sel;
          rvalid_d = 1'b1;
        end else if (cnt_q == CW'(TIMEOUT)) begin
          state_d  = DONE;
          err_d    = 1'b1;
          rdata_d  = '0;
          rvalid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      tgt_q     <= 3'b000;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
      s_valid_q <= 3'b000;
      rvalid_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      tgt_q     <= tgt_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      s_valid_q <= s_valid_d;
      rvalid_q  <= rvalid_d;
    end
  end

  // Gated by reset_n so every output reads 0 while reset is held.
  assign m_ready  = reset_n && (state_q == IDLE);
  assign m_rvalid = rvalid_q;
  assign m_rdata  = rdata_q;
  assign m_err    = err_q;
  assign s_valid  = s_valid_q;
  assign s_addr   = addr_q;
  assign s_we     = we_q;
  assign s_wdata  = wdata_q;

endmodule

// File: doc/bus_demux.md
BUS_DEMUX -- requirements
Module: bus_demux

Interface
REQ-001 Parameter WIDTH SHALL default to 32; it is the data width of m_wdata, m_rdata, s_wdata and each s_rdata slice.
REQ-002 Parameter TIMEOUT SHALL default to 15; it is the maximum number of cycles the block waits for a slave read response.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset_n  input  1  reset, asynchronous and active-low.
REQ-005 m_valid  input  1  master request valid.
REQ-006 m_ready  output  1  block accepts a request.
REQ-007 m_addr  input  32  request byte address.
REQ-008 m_we  input  1  1 = write, 0 = read.
REQ-009 m_wdata  input  WIDTH  write data.
REQ-010 m_rvalid  output  1  one-cycle completion pulse.
REQ-011 m_rdata  output  WIDTH  read data, qualified by m_rvalid.
REQ-012 m_err  output  1  error flag, qualified by m_rvalid.
REQ-013 s_valid  output  3  one-hot request strobe; bit 0 = DM, bit 1 = TC0, bit 2 = TC1.
REQ-014 s_ready  input  3  per-slave request accept.
REQ-015 s_addr, s_we, s_wdata  output  32/1/WIDTH  shared request fields, driven from the held request.
REQ-016 s_rvalid  input  3  per-slave read-data valid.
REQ-017 s_rdata  input  3*WIDTH  slice k is bits [k*WIDTH +: WIDTH].

Function
REQ-018 Address decode SHALL be:
- DM for 0x0000_0000–0x0000_2FFF;
- TC0 for 0x0000_7F00–0x0000_7F0B;
- TC1 for 0x0000_7F10–0x0000_7F1B;
- any other address is unmapped.
REQ-019 The FSM SHALL have four states: IDLE, REQ, WAIT and DONE.
REQ-020 m_ready SHALL be 1 only in IDLE.
REQ-021 In IDLE, m_valid=1 SHALL capture addr/we/wdata and the decoded target into holding registers.
- Mapped target: next state is REQ.
- Unmapped target: next state is DONE with err=1 and rdata=0.
REQ-022 In REQ, the block SHALL assert s_valid[target] only, and hold it until s_ready[target]=1.
REQ-023 On the REQ handshake, a write SHALL go to DONE with err=0 and rdata=0.
REQ-024 On the REQ handshake, a read SHALL go to WAIT and clear the timeout counter.
REQ-025 In WAIT, s_rvalid[target]=1 SHALL capture the s_rdata slice for that target and go to DONE with err=0.
REQ-026 s_rvalid bits for non-target slaves SHALL be ignored in every state.
REQ-027 In WAIT, the counter SHALL increment each cycle without a response.
- When the counter equals TIMEOUT with no response, the block SHALL go to DONE with err=1 and rdata=0.
- A response arriving in that same cycle SHALL take priority over the timeout.
REQ-028 In DONE, m_rvalid SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-029 m_rdata and m_err SHALL be registered and stable throughout DONE.
REQ-030 Latencies from the m_valid accept edge to m_rvalid SHALL be:
- unmapped access: 1 cycle;
- write with immediate s_ready: 2 cycles;
- read with immediate s_ready and s_rvalid: 3 cycles.
REQ-031 At most one transaction SHALL be outstanding, and m_valid SHALL be ignored outside IDLE.
REQ-032 Changes to m_* inputs after capture SHALL NOT affect s_* outputs.
REQ-033 The s_valid vector SHALL never have more than one bit set.

Reset
REQ-034 reset_n=0 SHALL immediately force the following, independent of clk:
- state = IDLE;
- s_valid = 0, m_rvalid = 0, m_err = 0;
- m_rdata = 0, holding registers = 0, counter = 0.
REQ-035 Reset asserted mid-transaction SHALL abort it with no m_rvalid pulse.
REQ-036 After reset_n rises, m_ready SHALL be 1 on the first clock edge.

Verification
REQ-037 Write: m_addr=0x0000_0010, m_we=1, m_wdata=0xDEADBEEF, s_ready=3'b001 -> s_valid=001 with s_wdata=0xDEADBEEF for one cycle; m_rvalid=1, m_err=0 two cycles after accept.
REQ-038 Read TC1 with s_ready delayed 3 cycles and s_rvalid[2] 2 cycles later with slice=0x0000_00A5 -> s_valid=100 held for 4 cycles; m_rdata=0x0000_00A5, m_err=0.
REQ-039 Unmapped read at m_addr=0x0000_4000 -> s_valid stays 000; m_rvalid=1, m_err=1, m_rdata=0 one cycle after accept.
REQ-040 Timeout: read of TC0 accepted by slave, s_rvalid never asserted -> m_err=1 exactly TIMEOUT+1 cycles after the handshake; spurious s_rvalid[0] during a TC1 read is ignored.
REQ-041 reset_n pulsed low during WAIT -> all outputs 0 asynchronously; no m_rvalid afterwards; m_ready=1 after release.
REQ-042 Back-to-back: m_valid held high across two DM writes -> second accepted only on the first IDLE cycle after DONE; at most one s_valid bit set in every cycle.
